// File: rtl/stopwatch_pkg.sv
// Shared types and the BCD increment helper for the stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Returns {carry_out, value + 1} over four BCD digits; carry_out marks 9999 -> 0000.
  function automatic logic [16:0] bcd_inc(input logic [15:0] value);
    logic [15:0] res;
    logic        carry;
    bcd_digit_t  d;
    carry = 1'b1;
    res   = value;
    for (int i = 0; i < 4; i++) begin
      d = value[4*i +: 4];
      if (carry) begin
        if (d >= BCD_MAX) begin
          d = 4'd0;
        end else begin
          d     = d + 4'd1;
          carry = 1'b0;
        end
      end
      res[4*i +: 4] = d;
    end
    return {carry, res};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button to one-cycle press pulse: 2-flop synchroniser, stability counter, rising-edge detect.
// Pin-to-pulse latency is 2 + DEBOUNCE_TICKS cycles.
module btn_debounce #(
  parameter int DEBOUNCE_TICKS = 5
) (
  input  logic ms_4_clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge ms_4_clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      // Any sample that agrees with the accepted level restarts the stability count.
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
          press <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/stopwatch_bcd.sv
// 4-digit BCD stopwatch (000.0..999.9 s) on the 4 ms scan tick with start/pause, clear and lap buttons.
// Lap hold is built only when LAP_EN is defined; otherwise btn_lap is ignored.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_STEP = 25,
  parameter int DEBOUNCE_TICKS = 5
) (
  input  logic        ms_4_clk,
  input  logic        reset,
  input  logic        btn_start,
  input  logic        btn_clear,
  input  logic        btn_lap,
  output logic [15:0] disp_value,
  output logic        running,
  output logic        overflow
);

  localparam int PW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICKS_PER_STEP - 1);

  sw_state_t   state;
  sw_state_t   state_nxt;
  logic [PW-1:0] presc;
  logic [15:0] count;
  logic [16:0] inc_res;
  logic        start_p;
  logic        clear_p;
  logic        step;

  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_start (
    .ms_4_clk (ms_4_clk),
    .reset    (reset),
    .raw      (btn_start),
    .press    (start_p)
  );

  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_clear (
    .ms_4_clk (ms_4_clk),
    .reset    (reset),
    .raw      (btn_clear),
    .press    (clear_p)
  );

  always_ff @(posedge ms_4_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    step      = (state == RUN) && (presc == PS_LAST);
    if (clear_p) begin
      state_nxt = IDLE;
    end else if (start_p) begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN:     state_nxt = PAUSE;
        PAUSE:   state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign inc_res = bcd_inc(count);

  // The prescaler is only frozen outside RUN, so a pause keeps the partial step.
  always_ff @(posedge ms_4_clk or posedge reset) begin
    if (reset) begin
      presc    <= '0;
      count    <= '0;
      overflow <= 1'b0;
      running  <= 1'b0;
    end else begin
      running <= (state_nxt == RUN);
      if (clear_p) begin
        presc    <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else if (state == RUN) begin
        if (step) begin
          presc <= '0;
          count <= inc_res[15:0];
          if (inc_res[16]) begin
            overflow <= 1'b1;
          end
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

`ifdef LAP_EN
  logic        lap_p;
  logic        hold;
  logic [15:0] hold_value;

  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_lap (
    .ms_4_clk (ms_4_clk),
    .reset    (reset),
    .raw      (btn_lap),
    .press    (lap_p)
  );

  always_ff @(posedge ms_4_clk or posedge reset) begin
    if (reset) begin
      hold       <= 1'b0;
      hold_value <= '0;
    end else if (clear_p) begin
      hold <= 1'b0;
    end else if (lap_p) begin
      if (hold) begin
        hold <= 1'b0;
      end else if (state == RUN) begin
        hold       <= 1'b1;
        hold_value <= count;
      end
    end
  end

  assign disp_value = hold ? hold_value : count;
`else
  logic unused_lap;
  assign unused_lap = btn_lap;
  assign disp_value = count;
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd with TICKS_PER_STEP=2, DEBOUNCE_TICKS=2: vector table plus corner sequences.
// Define LAP_EN when compiling to exercise the lap hold.
module tb_stopwatch_bcd;

  localparam int OP_WAIT   = 0;
  localparam int OP_START  = 1;
  localparam int OP_CLEAR  = 2;
  localparam int OP_LAP    = 3;
  localparam int OP_GLITCH = 4;
  localparam int OP_BOTH   = 5;

`ifdef LAP_EN
  localparam bit LAP_ON = 1'b1;
`else
  localparam bit LAP_ON = 1'b0;
`endif

  typedef struct {
    int          op;
    int          n;
    logic        exp_run;
    logic [15:0] exp_disp;
  } vec_t;

  logic        ms_4_clk = 1'b0;
  logic        reset;
  logic        btn_start;
  logic        btn_clear;
  logic        btn_lap;
  logic [15:0] disp_value;
  logic        running;
  logic        overflow;

  int total  = 0;
  int passed = 0;

  vec_t tbl[23];

  stopwatch_bcd #(.TICKS_PER_STEP(2), .DEBOUNCE_TICKS(2)) dut (
    .ms_4_clk   (ms_4_clk),
    .reset      (reset),
    .btn_start  (btn_start),
    .btn_clear  (btn_clear),
    .btn_lap    (btn_lap),
    .disp_value (disp_value),
    .running    (running),
    .overflow   (overflow)
  );

  always #5 ms_4_clk = ~ms_4_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic set_pins(input int op, input logic val);
    if (op == OP_START || op == OP_GLITCH || op == OP_BOTH) btn_start = val;
    if (op == OP_CLEAR || op == OP_BOTH) btn_clear = val;
    if (op == OP_LAP) btn_lap = val;
  endtask

  // Held 3 cycles; the FSM acts on the 5th rising edge after the pin goes high.
  // Returns 1 time unit after that edge.
  task automatic press(input int op);
    @(negedge ms_4_clk);
    set_pins(op, 1'b1);
    repeat (3) @(posedge ms_4_clk);
    @(negedge ms_4_clk);
    set_pins(op, 1'b0);
    repeat (2) @(posedge ms_4_clk);
    #1;
  endtask

  // Single-cycle pulse, then the same 5-edge footprint as a press.
  task automatic glitch(input int op);
    @(negedge ms_4_clk);
    set_pins(op, 1'b1);
    @(posedge ms_4_clk);
    @(negedge ms_4_clk);
    set_pins(op, 1'b0);
    repeat (4) @(posedge ms_4_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge ms_4_clk);
      #1;
    end
  endtask

  task automatic wait_value(input logic [15:0] v, input int limit, input string name);
    int k;
    k = 0;
    while (disp_value !== v && k < limit) begin
      @(posedge ms_4_clk);
      #1;
      k++;
    end
    check(name, {31'b0, disp_value === v}, 32'd1);
  endtask

  initial begin
    // op, extra wait cycles, expected running, expected disp_value (sampled after the wait)
    tbl[0]  = '{OP_START,  0, 1'b1, 16'h0000};
    tbl[1]  = '{OP_WAIT,  20, 1'b1, 16'h0010};
    tbl[2]  = '{OP_START,  0, 1'b0, 16'h0012};
    tbl[3]  = '{OP_WAIT,  10, 1'b0, 16'h0012};
    tbl[4]  = '{OP_START,  0, 1'b1, 16'h0012};
    tbl[5]  = '{OP_WAIT,   1, 1'b1, 16'h0013};
    tbl[6]  = '{OP_WAIT,   8, 1'b1, 16'h0017};
    tbl[7]  = '{OP_CLEAR,  0, 1'b0, 16'h0000};
    tbl[8]  = '{OP_WAIT,  10, 1'b0, 16'h0000};
    tbl[9]  = '{OP_GLITCH, 8, 1'b0, 16'h0000};
    tbl[10] = '{OP_START,  0, 1'b1, 16'h0000};
    tbl[11] = '{OP_WAIT,   4, 1'b1, 16'h0002};
    tbl[12] = '{OP_BOTH,   0, 1'b0, 16'h0000};
    tbl[13] = '{OP_WAIT,   4, 1'b0, 16'h0000};
    tbl[14] = '{OP_START,  0, 1'b1, 16'h0000};
    tbl[15] = '{OP_WAIT,   4, 1'b1, 16'h0002};
    tbl[16] = '{OP_LAP,    0, 1'b1, 16'h0004};
    tbl[17] = '{OP_WAIT,   4, 1'b1, LAP_ON ? 16'h0004 : 16'h0006};
    tbl[18] = '{OP_START,  0, 1'b0, LAP_ON ? 16'h0004 : 16'h0009};
    tbl[19] = '{OP_LAP,    0, 1'b0, 16'h0009};
    tbl[20] = '{OP_LAP,    0, 1'b0, 16'h0009};
    tbl[21] = '{OP_CLEAR,  0, 1'b0, 16'h0000};
    tbl[22] = '{OP_LAP,    2, 1'b0, 16'h0000};

    reset     = 1'b1;
    btn_start = 1'b0;
    btn_clear = 1'b0;
    btn_lap   = 1'b0;
    idle(3);
    check("reset disp", {16'b0, disp_value}, 32'h0);
    check("reset running", {31'b0, running}, 32'h0);
    check("reset overflow", {31'b0, overflow}, 32'h0);
    @(negedge ms_4_clk);
    reset = 1'b0;
    idle(3);

    for (int i = 0; i < 23; i++) begin
      if (tbl[i].op == OP_GLITCH) glitch(tbl[i].op);
      else if (tbl[i].op != OP_WAIT) press(tbl[i].op);
      idle(tbl[i].n);
      check($sformatf("row%0d disp", i), {16'b0, disp_value}, {16'b0, tbl[i].exp_disp});
      check($sformatf("row%0d running", i), {31'b0, running}, {31'b0, tbl[i].exp_run});
      check($sformatf("row%0d overflow", i), {31'b0, overflow}, 32'h0);
    end

    // Asynchronous reset in the middle of a run.
    press(OP_START);
    wait_value(16'h0123, 1000, "reach 0123");
    #2;
    reset = 1'b1;
    #1;
    check("async reset disp", {16'b0, disp_value}, 32'h0);
    check("async reset running", {31'b0, running}, 32'h0);
    @(posedge ms_4_clk);
    #1;
    check("reset sample disp", {16'b0, disp_value}, 32'h0);
    check("reset sample running", {31'b0, running}, 32'h0);
    check("reset sample overflow", {31'b0, overflow}, 32'h0);
    @(negedge ms_4_clk);
    reset = 1'b0;
    idle(6);
    check("post reset stays idle", {16'b0, disp_value}, 32'h0);

    // Full-range wrap and sticky overflow.
    press(OP_START);
    wait_value(16'h9999, 45000, "reach 9999");
    check("no overflow at 9999", {31'b0, overflow}, 32'h0);
    idle(2);
    check("wrap disp", {16'b0, disp_value}, 32'h0);
    check("wrap overflow", {31'b0, overflow}, 32'h1);
    idle(6);
    check("after wrap disp", {16'b0, disp_value}, 32'h0003);
    check("overflow sticky", {31'b0, overflow}, 32'h1);
    press(OP_CLEAR);
    check("clear overflow", {31'b0, overflow}, 32'h0);
    check("clear disp", {16'b0, disp_value}, 32'h0);
    check("clear running", {31'b0, running}, 32'h0);

`ifdef LAP_EN
    // Lap captured at 0042, held while counting continues, released onto 0047.
    press(OP_START);
    wait_value(16'h0040, 200, "reach 0040");
    press(OP_LAP);
    check("lap capture", {16'b0, disp_value}, 32'h0042);
    for (int k = 0; k < 5; k++) begin
      idle(1);
      check($sformatf("lap hold %0d", k), {16'b0, disp_value}, 32'h0042);
    end
    press(OP_LAP);
    check("lap release", {16'b0, disp_value}, 32'h0047);
    idle(1);
    check("lap follows", {16'b0, disp_value}, 32'h0048);
    press(OP_CLEAR);
    check("lap clear", {16'b0, disp_value}, 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
